// File: rtl/comp_gbe_framer.sv
// Drains 9 x 48-bit hit words from the comparator FIFO and frames them as 16-bit GbE words.
// Define COMPGBE_CHKSUM_EN to replace the constant trailer with a 16-bit sum of header and data.
module comp_gbe_framer #(
    parameter int          PRE_WORDS = 4,
    parameter logic [15:0] PRE_WORD  = 16'h50BC,
    parameter int          STALL_MAX = 255,
    parameter int          GAP_WORDS = 2
) (
    input  logic        fabric_clk,
    input  logic        reset_n,
    input  logic        compfifo_dav,
    input  logic        compfifo_overflow,
    input  logic [47:0] compfifo_dout,
    output logic        en_fiforead,
    output logic [15:0] tx_dat,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic [15:0] pkt_count,
    output logic        trunc_err,
    output logic        ovf_seen,
    input  logic        clr_flags
);

    localparam int PRE_W   = (PRE_WORDS < 2) ? 1 : $clog2(PRE_WORDS);
    localparam int GAP_W   = (GAP_WORDS < 2) ? 1 : $clog2(GAP_WORDS);
    localparam int STALL_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
    localparam logic [15:0] PAD_WORD = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE, ST_PRE, ST_HDR, ST_FETCH, ST_WAIT, ST_DATA, ST_TRL, ST_GAP
    } state_t;

    state_t             state_r;
    logic [PRE_W-1:0]   pre_cnt_r;
    logic [GAP_W-1:0]   gap_cnt_r;
    logic [STALL_W-1:0] stall_r;
    logic [1:0]         beat_r;
    logic [3:0]         word_idx_r;
    logic [47:0]        hold_r;
    logic               padded_r;
    logic [1:0]         hdr_flags_r;
    logic               accept_s;
    logic [15:0]        header_s;
    logic [15:0]        trailer_s;
    logic [15:0]        next_slice_s;

    assign accept_s = tx_valid & tx_ready;
    assign header_s = {hdr_flags_r, 2'b00, pkt_count[11:0]};

    // The read strobe must land in the FETCH cycle itself so the word is in hand during WAIT.
    assign en_fiforead = (state_r == ST_FETCH) & compfifo_dav;

`ifdef COMPGBE_CHKSUM_EN
    logic [15:0] sum_r;

    // Running sum of header and data words accepted so far in this packet.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_r <= 16'h0000;
        end else if (state_r == ST_IDLE) begin
            sum_r <= 16'h0000;
        end else if (accept_s && ((state_r == ST_HDR) || (state_r == ST_DATA))) begin
            sum_r <= sum_r + tx_dat;
        end
    end

    assign trailer_s = sum_r + tx_dat;
`else
    assign trailer_s = 16'hE0FF;
`endif

    // Word to present after the current data beat is accepted.
    always_comb begin
        next_slice_s = PAD_WORD;
        if (padded_r) begin
            next_slice_s = PAD_WORD;
        end else begin
            case (beat_r)
                2'd0:    next_slice_s = hold_r[31:16];
                2'd1:    next_slice_s = hold_r[15:0];
                default: next_slice_s = hold_r[47:32];
            endcase
        end
    end

    // Overflow flag; a set in the same cycle as a clear takes priority.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_seen <= 1'b0;
        end else if (compfifo_overflow) begin
            ovf_seen <= 1'b1;
        end else if (clr_flags) begin
            ovf_seen <= 1'b0;
        end
    end

    // Framing FSM with registered transmit outputs, packet counter and truncation flag.
    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            pre_cnt_r   <= '0;
            gap_cnt_r   <= '0;
            stall_r     <= '0;
            beat_r      <= 2'd0;
            word_idx_r  <= 4'd0;
            hold_r      <= 48'h0;
            padded_r    <= 1'b0;
            hdr_flags_r <= 2'b00;
            tx_dat      <= 16'h0000;
            tx_valid    <= 1'b0;
            tx_sop      <= 1'b0;
            tx_eop      <= 1'b0;
            pkt_count   <= 16'h0000;
            trunc_err   <= 1'b0;
        end else begin
            if (clr_flags) begin
                trunc_err <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    word_idx_r <= 4'd0;
                    padded_r   <= 1'b0;
                    stall_r    <= '0;
                    beat_r     <= 2'd0;
                    if (compfifo_dav) begin
                        hdr_flags_r <= {ovf_seen, trunc_err};
                        pre_cnt_r   <= '0;
                        tx_dat      <= PRE_WORD;
                        tx_valid    <= 1'b1;
                        tx_sop      <= 1'b1;
                        state_r     <= ST_PRE;
                    end
                end
                ST_PRE: begin
                    if (accept_s) begin
                        tx_sop <= 1'b0;
                        if (pre_cnt_r == PRE_W'(PRE_WORDS - 1)) begin
                            tx_dat  <= header_s;
                            state_r <= ST_HDR;
                        end else begin
                            pre_cnt_r <= pre_cnt_r + PRE_W'(1);
                        end
                    end
                end
                ST_HDR: begin
                    if (accept_s) begin
                        tx_valid <= 1'b0;
                        tx_dat   <= 16'h0000;
                        state_r  <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (compfifo_dav) begin
                        state_r <= ST_WAIT;
                    end else if (stall_r == STALL_W'(STALL_MAX)) begin
                        trunc_err <= 1'b1;
                        padded_r  <= 1'b1;
                        stall_r   <= '0;
                        beat_r    <= 2'd0;
                        tx_dat    <= PAD_WORD;
                        tx_valid  <= 1'b1;
                        state_r   <= ST_DATA;
                    end else begin
                        stall_r <= stall_r + STALL_W'(1);
                    end
                end
                ST_WAIT: begin
                    hold_r   <= compfifo_dout;
                    stall_r  <= '0;
                    beat_r   <= 2'd0;
                    tx_dat   <= compfifo_dout[47:32];
                    tx_valid <= 1'b1;
                    state_r  <= ST_DATA;
                end
                ST_DATA: begin
                    if (accept_s) begin
                        if (beat_r == 2'd2) begin
                            beat_r     <= 2'd0;
                            word_idx_r <= word_idx_r + 4'd1;
                            if (word_idx_r == 4'd8) begin
                                tx_dat  <= trailer_s;
                                tx_eop  <= 1'b1;
                                state_r <= ST_TRL;
                            end else if (padded_r) begin
                                tx_dat <= PAD_WORD;
                            end else begin
                                tx_valid <= 1'b0;
                                tx_dat   <= 16'h0000;
                                state_r  <= ST_FETCH;
                            end
                        end else begin
                            beat_r <= beat_r + 2'd1;
                            tx_dat <= next_slice_s;
                        end
                    end
                end
                ST_TRL: begin
                    if (accept_s) begin
                        tx_valid  <= 1'b0;
                        tx_eop    <= 1'b0;
                        tx_dat    <= 16'h0000;
                        pkt_count <= pkt_count + 16'd1;
                        gap_cnt_r <= '0;
                        state_r   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_r == GAP_W'(GAP_WORDS - 1)) begin
                        state_r <= ST_IDLE;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_sop   <= 1'b0;
                    tx_eop   <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_gbe_framer.sv
// Directed bench for comp_gbe_framer: FIFO model, word monitor and hand-derived frame expectations.
module tb_comp_gbe_framer;

    localparam int PRE_WORDS = 4;
    localparam int GAP_WORDS = 2;
    localparam int PKT_LEN   = PRE_WORDS + 1 + 27 + 1;

    logic        fabric_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        compfifo_dav = 1'b0;
    logic        compfifo_overflow = 1'b0;
    logic [47:0] compfifo_dout = 48'h0;
    logic        tx_ready = 1'b0;
    logic        clr_flags = 1'b0;
    logic        en_fiforead;
    logic [15:0] tx_dat;
    logic        tx_valid;
    logic        tx_sop;
    logic        tx_eop;
    logic [15:0] pkt_count;
    logic        trunc_err;
    logic        ovf_seen;

    always #5 fabric_clk = ~fabric_clk;

    comp_gbe_framer dut (
        .fabric_clk        (fabric_clk),
        .reset_n           (reset_n),
        .compfifo_dav      (compfifo_dav),
        .compfifo_overflow (compfifo_overflow),
        .compfifo_dout     (compfifo_dout),
        .en_fiforead       (en_fiforead),
        .tx_dat            (tx_dat),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_sop            (tx_sop),
        .tx_eop            (tx_eop),
        .pkt_count         (pkt_count),
        .trunc_err         (trunc_err),
        .ovf_seen          (ovf_seen),
        .clr_flags         (clr_flags)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO model: standard read, data one cycle after the strobe, registered not-empty flag.
    logic [47:0] fifo_q[$];
    int          rd_cnt = 0;
    int          cyc = 0;
    always @(posedge fabric_clk) begin
        cyc <= cyc + 1;
        if (en_fiforead && (fifo_q.size() != 0)) begin
            compfifo_dout <= fifo_q.pop_front();
            rd_cnt        <= rd_cnt + 1;
        end
        compfifo_dav <= (fifo_q.size() != 0);
    end

    // Monitor on the falling edge: accepted words and read-strobe legality.
    logic [15:0] rx_q[$];
    bit          rx_sop_q[$];
    bit          rx_eop_q[$];
    int          rx_cyc_q[$];
    int          eop_cnt = 0;
    int          rd_viol = 0;
    logic        en_prev = 1'b0;
    always @(negedge fabric_clk) begin
        if (reset_n && tx_valid && tx_ready) begin
            rx_q.push_back(tx_dat);
            rx_sop_q.push_back(tx_sop);
            rx_eop_q.push_back(tx_eop);
            rx_cyc_q.push_back(cyc);
            if (tx_eop) eop_cnt <= eop_cnt + 1;
        end
        if (en_fiforead && (!compfifo_dav || en_prev)) rd_viol <= rd_viol + 1;
        en_prev <= en_fiforead;
    end

    bit rdy_rand = 1'b0;
    initial begin
        forever begin
            @(posedge fabric_clk);
            #2;
            tx_ready = rdy_rand ? 1'($urandom_range(1, 0)) : 1'b1;
        end
    end

    logic [47:0] pkt_data [9];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fabric_clk);
            #2;
        end
    endtask

    task automatic fill(input int seed);
        for (int k = 0; k < 9; k++)
            pkt_data[k] = {16'(seed * 4369 + k), 16'(16'hA5A5 ^ (k * 291)), 16'(65535 - seed - k * 257)};
    endtask

    task automatic push(input int first, input int count);
        for (int k = first; k < first + count; k++) fifo_q.push_back(pkt_data[k]);
    endtask

    task automatic rx_clear();
        rx_q.delete();
        rx_sop_q.delete();
        rx_eop_q.delete();
        rx_cyc_q.delete();
    endtask

    task automatic wait_packet(input string tag, input int budget);
        int start;
        int n;
        start = eop_cnt;
        n = 0;
        while ((eop_cnt == start) && (n < budget)) begin
            tick(1);
            n++;
        end
        check_val({tag, "_eop_seen"}, 32'(eop_cnt - start), 32'd1);
        tick(GAP_WORDS + 2);
    endtask

    task automatic expect_packet(input string tag, input logic [15:0] hdr, input int nvalid);
        logic [15:0] exp_q[$];
        logic [15:0] sum;
        logic [15:0] w;
        int          sops;
        int          eops;
        for (int i = 0; i < PRE_WORDS; i++) exp_q.push_back(16'h50BC);
        exp_q.push_back(hdr);
        sum = hdr;
        for (int k = 0; k < 9; k++) begin
            for (int b = 2; b >= 0; b--) begin
                w = (k < nvalid) ? pkt_data[k][b*16 +: 16] : 16'hDEAD;
                exp_q.push_back(w);
                sum = sum + w;
            end
        end
`ifdef COMPGBE_CHKSUM_EN
        exp_q.push_back(sum);
`else
        exp_q.push_back(16'hE0FF);
`endif
        check_val({tag, "_len"}, 32'(rx_q.size()), 32'(PKT_LEN));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < rx_q.size()) check_val($sformatf("%s_w%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
        sops = 0;
        eops = 0;
        foreach (rx_sop_q[i]) begin
            if (rx_sop_q[i]) sops++;
            if (rx_eop_q[i]) eops++;
        end
        check_val({tag, "_sop_cnt"}, 32'(sops), 32'd1);
        check_val({tag, "_eop_cnt"}, 32'(eops), 32'd1);
        if (rx_q.size() == PKT_LEN) begin
            check_val({tag, "_sop_first"}, 32'(rx_sop_q[0]), 32'd1);
            check_val({tag, "_eop_last"}, 32'(rx_eop_q[PKT_LEN-1]), 32'd1);
        end
    endtask

    initial begin
        int rd0;
        int n;

        tick(3);
        check_val("rst_valid", 32'(tx_valid), 32'd0);
        check_val("rst_dat", 32'(tx_dat), 32'd0);
        check_val("rst_sop", 32'(tx_sop), 32'd0);
        check_val("rst_eop", 32'(tx_eop), 32'd0);
        check_val("rst_cnt", 32'(pkt_count), 32'd0);
        check_val("rst_trunc", 32'(trunc_err), 32'd0);
        check_val("rst_ovf", 32'(ovf_seen), 32'd0);
        check_val("rst_rd", 32'(en_fiforead), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Packet 1: preloaded record, free-running sink, latency checks.
        fill(1);
        rx_clear();
        rd0 = rd_cnt;
        push(0, 9);
        wait_packet("p1", 300);
        expect_packet("p1", 16'h0000, 9);
        check_val("p1_cnt", 32'(pkt_count), 32'd1);
        check_val("p1_reads", 32'(rd_cnt - rd0), 32'd9);
        if (rx_q.size() == PKT_LEN) begin
            check_val("p1_first_data_lat", 32'(rx_cyc_q[PRE_WORDS+1] - rx_cyc_q[0]), 32'(PRE_WORDS + 3));
            check_val("p1_trailer_lat", 32'(rx_cyc_q[PKT_LEN-1] - rx_cyc_q[0]), 32'(PRE_WORDS + 1 + 45));
        end

        // Packet 2: FIFO runs dry for ~100 cycles mid-record, then refills.
        fill(2);
        rx_clear();
        rd0 = rd_cnt;
        push(0, 4);
        n = 0;
        while ((rd_cnt - rd0 < 4) && (n < 300)) begin
            tick(1);
            n++;
        end
        check_val("p2_first_reads", 32'(rd_cnt - rd0), 32'd4);
        tick(100);
        push(4, 5);
        wait_packet("p2", 600);
        expect_packet("p2", 16'h0001, 9);
        check_val("p2_trunc", 32'(trunc_err), 32'd0);
        check_val("p2_cnt", 32'(pkt_count), 32'd2);
        check_val("p2_reads", 32'(rd_cnt - rd0), 32'd9);

        // Packet 3: FIFO never refills, record padded after the stall limit.
        fill(3);
        rx_clear();
        rd0 = rd_cnt;
        push(0, 4);
        wait_packet("p3", 1200);
        expect_packet("p3", 16'h0002, 4);
        check_val("p3_trunc", 32'(trunc_err), 32'd1);
        check_val("p3_reads", 32'(rd_cnt - rd0), 32'd4);
        check_val("p3_cnt", 32'(pkt_count), 32'd3);

        // Packet 4: header reports the earlier truncation; then clear it.
        fill(4);
        rx_clear();
        push(0, 9);
        wait_packet("p4", 300);
        expect_packet("p4", 16'h4003, 9);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check_val("p4_trunc_clr", 32'(trunc_err), 32'd0);

        // Packet 5: random back-pressure, same record as packet 1.
        fill(1);
        rx_clear();
        rd0 = rd_cnt;
        rdy_rand = 1'b1;
        push(0, 9);
        wait_packet("p5", 2000);
        rdy_rand = 1'b0;
        tick(2);
        expect_packet("p5", 16'h0004, 9);
        check_val("p5_reads", 32'(rd_cnt - rd0), 32'd9);
        check_val("p5_cnt", 32'(pkt_count), 32'd5);

        // Packet 6: overflow and clear in the same cycle mid-packet.
        fill(6);
        rx_clear();
        push(0, 9);
        tick(20);
        compfifo_overflow = 1'b1;
        clr_flags = 1'b1;
        tick(1);
        compfifo_overflow = 1'b0;
        clr_flags = 1'b0;
        check_val("p6_ovf_set_wins", 32'(ovf_seen), 32'd1);
        wait_packet("p6", 300);
        expect_packet("p6", 16'h0005, 9);

        // Packet 7: header carries the overflow bit.
        fill(7);
        rx_clear();
        push(0, 9);
        wait_packet("p7", 300);
        expect_packet("p7", 16'h8006, 9);
        clr_flags = 1'b1;
        tick(1);
        clr_flags = 1'b0;
        check_val("p7_ovf_clr", 32'(ovf_seen), 32'd0);
        check_val("p7_cnt", 32'(pkt_count), 32'd7);

        // Reset mid-frame drops tx_valid at once.
        fill(8);
        push(0, 9);
        n = 0;
        while (!tx_valid && (n < 100)) begin
            tick(1);
            n++;
        end
        check_val("abort_valid_before", 32'(tx_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check_val("abort_valid", 32'(tx_valid), 32'd0);
        check_val("abort_sop", 32'(tx_sop), 32'd0);
        check_val("abort_cnt", 32'(pkt_count), 32'd0);
        check_val("abort_rd", 32'(en_fiforead), 32'd0);
        fifo_q.delete();
        tick(3);
        rx_clear();
        reset_n = 1'b1;
        tick(3);

        // Packet 9: all-ones data after reset, header 0000.
        for (int k = 0; k < 9; k++) pkt_data[k] = 48'hFFFF_FFFF_FFFF;
        rx_clear();
        push(0, 9);
        wait_packet("p9", 300);
        expect_packet("p9", 16'h0000, 9);
        if (rx_q.size() > 0) begin
`ifdef COMPGBE_CHKSUM_EN
            check_val("p9_trailer_const", 32'(rx_q[rx_q.size()-1]), 32'h0000FFE5);
`else
            check_val("p9_trailer_const", 32'(rx_q[rx_q.size()-1]), 32'h0000E0FF);
`endif
        end
        check_val("p9_cnt", 32'(pkt_count), 32'd1);

        check_val("rd_strobe_legal", 32'(rd_viol), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
